axi4_slave_write_resp_channel: RTL and testbench

// AXI4 slave B-channel stage, directly downstream of the write-data channel.

---
 rtl/axi4_slave_pkg.sv | 18 +
 rtl/axi4_resp_fifo.sv | 61 ++++++
 rtl/axi4_slave_write_resp_channel.sv | 94 +++++++++
 tb/tb_axi4_slave_write_resp_channel.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slave_pkg.sv
// axi4_slave_pkg: shared B-channel types for the AXI4 slave write path
package axi4_slave_pkg;
    localparam int B_ID_W = 4;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;
    typedef struct packed {
        logic [B_ID_W-1:0] id;
        logic [1:0]        resp;
    } b_entry_t;
    typedef enum logic {
        B_IDLE  = 1'b0,
        B_VALID = 1'b1
    } b_state_t;
endpackage

// File: rtl/axi4_resp_fifo.sv
// axi4_resp_fifo: in-order queue of pending write responses with occupancy status
module axi4_resp_fifo
    import axi4_slave_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  b_entry_t                       i_din,
    output b_entry_t                       o_dout,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    b_entry_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            w_do_push;
    logic            w_do_pop;
    logic [CW-1:0]   w_count_nxt;

    // A push into a full queue is only taken when the same cycle frees a slot
    always_comb begin
        w_do_pop    = i_pop && (r_count != '0);
        w_do_push   = i_push && (!r_full || w_do_pop);
        w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
    end

    // Pointers, occupancy and full flag; full is registered alongside the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // Entry storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/axi4_slave_write_resp_channel.sv
// axi4_slave_write_resp_channel: queues write completions and presents them on the B channel
module axi4_slave_write_resp_channel
    import axi4_slave_pkg::*;
#(
    parameter int ID_WIDTH   = B_ID_W,
    parameter int RESP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              b_transfer_done,
    input  logic [ID_WIDTH-1:0]               b_bid,
    input  logic [1:0]                        b_bresp,
    input  logic                              bready,
    output logic                              bvalid,
    output logic [ID_WIDTH-1:0]               bid,
    output logic [1:0]                        bresp,
    output logic                              resp_full,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   resp_count,
    output logic                              resp_overflow
);
    b_state_t                          r_state;
    b_state_t                          w_state_nxt;
    logic [ID_WIDTH-1:0]               r_bid;
    logic [1:0]                        r_bresp;
    logic                              r_overflow;
    logic                              w_free;
    logic                              w_pop;
    logic                              w_bypass;
    logic                              w_push;
    logic                              w_load;
    logic                              w_drop;
    b_entry_t                          w_in;
    b_entry_t                          w_head;
    b_entry_t                          w_load_entry;
    logic [$clog2(RESP_DEPTH+1)-1:0]   w_count;
    logic                              w_full;
    logic                              w_empty;

    assign w_in = {b_bid, b_bresp};

    axi4_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_in),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output slot refill: queue head wins over a same-cycle completion to keep order
    always_comb begin
        w_free       = (r_state == B_IDLE) || bready;
        w_pop        = w_free && !w_empty;
        w_bypass     = w_free && w_empty && b_transfer_done;
        w_push       = b_transfer_done && !w_bypass;
        w_drop       = w_push && w_full && !w_pop;
        w_load       = w_pop || w_bypass;
        w_load_entry = w_pop ? w_head : w_in;
        w_state_nxt  = (w_load || !w_free) ? B_VALID : B_IDLE;
    end

    // FSM state register; B_VALID persists until a handshake with nothing to refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= B_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Output register only changes on a load, so bid/bresp stay stable under back-pressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bid   <= '0;
            r_bresp <= RESP_OKAY;
        end else if (w_load) begin
            r_bid   <= w_load_entry.id;
            r_bresp <= w_load_entry.resp;
        end
    end

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign bvalid        = (r_state == B_VALID);
    assign bid           = r_bid;
    assign bresp         = r_bresp;
    assign resp_full     = w_full;
    assign resp_count    = w_count;
    assign resp_overflow = r_overflow;
endmodule

// File: tb/tb_axi4_slave_write_resp_channel.sv
// tb_axi4_slave_write_resp_channel: directed scenarios plus randomized traffic against a pending-list model
module tb_axi4_slave_write_resp_channel;
    localparam int RESP_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_transfer_done = 1'b0;
    logic [3:0] b_bid = 4'h0;
    logic [1:0] b_bresp = 2'b00;
    logic       bready = 1'b0;
    logic       bvalid;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       resp_full;
    logic [2:0] resp_count;
    logic       resp_overflow;

    int checks = 0;
    int errors = 0;

    // Model: every accepted-but-unretired response in order; front is the one on the bus
    logic [5:0] m_q[$];
    bit         m_ovf = 1'b0;

    axi4_slave_write_resp_channel #(.ID_WIDTH(4), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .b_transfer_done (b_transfer_done),
        .b_bid           (b_bid),
        .b_bresp         (b_bresp),
        .bready          (bready),
        .bvalid          (bvalid),
        .bid             (bid),
        .bresp           (bresp),
        .resp_full       (resp_full),
        .resp_count      (resp_count),
        .resp_overflow   (resp_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (m_q.size() > 0 && bready) void'(m_q.pop_front());
            if (b_transfer_done) begin
                if (m_q.size() < RESP_DEPTH + 1) m_q.push_back({b_bid, b_bresp});
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({bvalid, bid, bresp, resp_count, resp_full, resp_overflow} !== 12'h0) begin
            errors++;
            $display("FAIL reset_async: got bvalid=%0b bid=%h bresp=%b cnt=%0d full=%0b ovf=%0b exp all 0",
                     bvalid, bid, bresp, resp_count, resp_full, resp_overflow);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bvalid, resp_count, resp_full, resp_overflow} !== 6'h0) begin
            errors++;
            $display("FAIL reset_release: got bvalid=%0b cnt=%0d full=%0b ovf=%0b exp 0 0 0 0",
                     bvalid, resp_count, resp_full, resp_overflow);
        end
    endtask

    task automatic test_single();
        bready = 1'b1;
        b_transfer_done = 1'b1;
        b_bid = 4'h3;
        b_bresp = 2'b00;
        tick();
        b_transfer_done = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'h3 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL single_latency: got bvalid=%0b bid=%h bresp=%b exp 1 3 00", bvalid, bid, bresp);
        end
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got bvalid=%0b exp 0", bvalid);
        end
    endtask

    task automatic test_back_pressure();
        bready = 1'b0;
        b_transfer_done = 1'b1;
        b_bresp = 2'b00;
        b_bid = 4'h1;
        tick();
        b_bid = 4'h2;
        tick();
        b_transfer_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bid !== 4'h1 || resp_count !== 3'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got bvalid=%0b bid=%h cnt=%0d exp 1 1 1", i, bvalid, bid, resp_count);
            end
            tick();
        end
        bready = 1'b1;
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'h1) begin
            errors++;
            $display("FAIL bp_first: got bvalid=%0b bid=%h exp 1 1", bvalid, bid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'h2 || resp_count !== 3'd0) begin
            errors++;
            $display("FAIL bp_second: got bvalid=%0b bid=%h cnt=%0d exp 1 2 0", bvalid, bid, resp_count);
        end
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got bvalid=%0b exp 0", bvalid);
        end
    endtask

    task automatic test_fill();
        bready = 1'b0;
        b_transfer_done = 1'b1;
        b_bresp = 2'b01;
        for (int i = 0; i < 5; i++) begin
            b_bid = 4'(i);
            tick();
        end
        checks++;
        if (resp_full !== 1'b1 || resp_count !== 3'd4 || resp_overflow !== 1'b0 || bid !== 4'h0) begin
            errors++;
            $display("FAIL fill_full: got full=%0b cnt=%0d ovf=%0b bid=%h exp 1 4 0 0",
                     resp_full, resp_count, resp_overflow, bid);
        end
        b_bid = 4'h5;
        tick();
        b_transfer_done = 1'b0;
        checks++;
        if (resp_overflow !== 1'b1 || resp_count !== 3'd4 || resp_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: got ovf=%0b cnt=%0d full=%0b exp 1 4 1", resp_overflow, resp_count, resp_full);
        end
        bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bid !== 4'(i) || bresp !== 2'b01) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got bvalid=%0b bid=%h bresp=%b exp 1 %h 01", i, bvalid, bid, bresp, 4'(i));
            end
            tick();
        end
        checks++;
        if (bvalid !== 1'b0 || resp_count !== 3'd0 || resp_full !== 1'b0 || resp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty: got bvalid=%0b cnt=%0d full=%0b ovf=%0b exp 0 0 0 1",
                     bvalid, resp_count, resp_full, resp_overflow);
        end
    endtask

    task automatic test_simultaneous();
        bready = 1'b0;
        b_transfer_done = 1'b1;
        b_bresp = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            b_bid = 4'(i);
            tick();
        end
        checks++;
        if (resp_count !== 3'd2 || bid !== 4'h1) begin
            errors++;
            $display("FAIL simul_setup: got cnt=%0d bid=%h exp 2 1", resp_count, bid);
        end
        bready = 1'b1;
        b_bid = 4'h4;
        tick();
        b_transfer_done = 1'b0;
        checks++;
        if (resp_count !== 3'd2 || bvalid !== 1'b1 || bid !== 4'h2) begin
            errors++;
            $display("FAIL simul_pushpop: got cnt=%0d bvalid=%0b bid=%h exp 2 1 2", resp_count, bvalid, bid);
        end
        for (int e = 3; e <= 4; e++) begin
            tick();
            checks++;
            if (bvalid !== 1'b1 || bid !== 4'(e)) begin
                errors++;
                $display("FAIL simul_order: got bvalid=%0b bid=%h exp 1 %h", bvalid, bid, 4'(e));
            end
        end
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL simul_idle: got bvalid=%0b exp 0", bvalid);
        end
    endtask

    task automatic test_error_passthrough();
        bready = 1'b1;
        b_transfer_done = 1'b1;
        b_bid = 4'hF;
        b_bresp = 2'b11;
        tick();
        b_transfer_done = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'hF || bresp !== 2'b11) begin
            errors++;
            $display("FAIL err_pass: got bvalid=%0b bid=%h bresp=%b exp 1 f 11", bvalid, bid, bresp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bready = 1'b0;
        b_transfer_done = 1'b1;
        b_bresp = 2'b10;
        for (int i = 6; i <= 9; i++) begin
            b_bid = 4'(i);
            tick();
        end
        b_transfer_done = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || resp_count !== 3'd3) begin
            errors++;
            $display("FAIL rmid_setup: got bvalid=%0b cnt=%0d exp 1 3", bvalid, resp_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bvalid, bid, bresp, resp_count, resp_full, resp_overflow} !== 12'h0) begin
            errors++;
            $display("FAIL rmid_async: got bvalid=%0b bid=%h bresp=%b cnt=%0d full=%0b ovf=%0b exp all 0",
                     bvalid, bid, bresp, resp_count, resp_full, resp_overflow);
        end
        tick();
        rst = 1'b1;
        bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bvalid !== 1'b0 || resp_count !== 3'd0) begin
                errors++;
                $display("FAIL rmid_noreplay[%0d]: got bvalid=%0b cnt=%0d exp 0 0", i, bvalid, resp_count);
            end
        end
        b_transfer_done = 1'b1;
        b_bid = 4'hA;
        b_bresp = 2'b01;
        tick();
        b_transfer_done = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'hA || bresp !== 2'b01) begin
            errors++;
            $display("FAIL rmid_new: got bvalid=%0b bid=%h bresp=%b exp 1 a 01", bvalid, bid, bresp);
        end
        tick();
    endtask

    task automatic test_random();
        int   e_cnt;
        logic e_valid;
        for (int i = 0; i < 900; i++) begin
            case ((i / 60) % 3)
                0:       bready = ($urandom_range(9) != 0);
                1:       bready = ($urandom_range(9) < 3);
                default: bready = ($urandom_range(19) == 0);
            endcase
            b_transfer_done = ($urandom_range(1) == 1);
            b_bid = 4'($urandom);
            b_bresp = 2'($urandom);
            tick();
            e_valid = (m_q.size() > 0);
            e_cnt = (m_q.size() > 0) ? m_q.size() - 1 : 0;
            checks++;
            if ({bvalid, resp_count, resp_full, resp_overflow} !== {e_valid, 3'(e_cnt), (e_cnt == RESP_DEPTH), m_ovf}) begin
                errors++;
                $display("FAIL rand_status[%0d]: got bvalid=%0b cnt=%0d full=%0b ovf=%0b exp %0b %0d %0b %0b",
                         i, bvalid, resp_count, resp_full, resp_overflow, e_valid, e_cnt, (e_cnt == RESP_DEPTH), m_ovf);
            end
            if (e_valid) begin
                checks++;
                if ({bid, bresp} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got bid=%h bresp=%b exp bid=%h bresp=%b",
                             i, bid, bresp, m_q[0][5:2], m_q[0][1:0]);
                end
            end
        end
        b_transfer_done = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bvalid !== 1'b0 || resp_count !== 3'd0) begin
            errors++;
            $display("FAIL rand_drain: got bvalid=%0b cnt=%0d exp 0 0", bvalid, resp_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_fill();
        test_simultaneous();
        test_error_passthrough();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
